// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants and point-encoder FSM encoding.
//   P_25519  : field prime 2^255 - 19
//   INV_EXP  : Fermat inversion exponent p - 2
//   MUL_LAT  : start-to-done latency of fe_mul_25519
//   state_t  : encoder state constants (legacy-compatible localparams)
//   mul_op_e : which product is currently in flight on the shared multiplier
package ed25519_pkg;

  localparam logic [254:0] P_25519 = ~255'd18;  // 2^255 - 1 - 18
  localparam logic [254:0] INV_EXP = ~255'd20;  // 2^255 - 21
  localparam int unsigned  MUL_LAT = 3;
  localparam logic [7:0]   INV_TOP_IDX = 8'd253;  // bit 254 is absorbed by seeding acc with Z

  typedef logic [3:0] state_t;

  localparam state_t StIdle    = 4'd0;
  localparam state_t StLoad    = 4'd1;
  localparam state_t StInvSqr  = 4'd2;
  localparam state_t StInvMul  = 4'd3;
  localparam state_t StAffX    = 4'd4;
  localparam state_t StAffY    = 4'd5;
  localparam state_t StMulWait = 4'd6;
  localparam state_t StStep    = 4'd7;
  localparam state_t StCanon   = 4'd8;
  localparam state_t StFinish  = 4'd9;

  typedef enum logic [1:0] {
    OpSqr,
    OpMul,
    OpAffX,
    OpAffY
  } mul_op_e;

  // Multiplier output is below 2^255 < 2p, so one conditional subtract is canonical.
  function automatic logic [254:0] canon_fe(input logic [254:0] v);
    return (v >= P_25519) ? (v - P_25519) : v;
  endfunction

endpackage

// File: rtl/point_encode_25519_if.sv
// Request/response bundle of the point encoder.
//   start        : one-cycle request (sampled only while idle)
//   in_x/y/z     : projective coordinates, captured on an accepted start
//   enc          : 256-bit compressed point
//   done         : one-cycle completion pulse
//   err          : Z was congruent to 0 mod p
//   busy         : encoder is not idle
interface point_encode_25519_if;

  logic         start;
  logic [254:0] in_x;
  logic [254:0] in_y;
  logic [254:0] in_z;
  logic [255:0] enc;
  logic         done;
  logic         err;
  logic         busy;

  modport master (
    output start, in_x, in_y, in_z,
    input  enc, done, err, busy
  );

  modport slave (
    input  start, in_x, in_y, in_z,
    output enc, done, err, busy
  );

endinterface

// File: rtl/fe_mul_25519.sv
// Pipelined field multiplier mod p = 2^255 - 19.
//   clk, rst : clock, asynchronous active-low reset
//   start    : one-cycle pulse, a/b sampled in the same cycle
//   a, b     : operands (any value below 2^255)
//   r        : a*b mod p, not necessarily canonical but below 2^255
//   done     : one-cycle pulse MUL_LAT cycles after start, r valid with it
module fe_mul_25519 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] r,
  output logic         done
);

  logic [509:0] prod_q;
  logic [260:0] fold_q;
  logic [254:0] r_q;
  logic         v1_q, v2_q, done_q;
  logic [255:0] fold2;
  logic [254:0] r_d;

  // Second fold: the high part of fold_q is tiny, so the result exceeds 2^255
  // by at most a few hundred and one more 2^255 -> 19 wrap finishes it.
  always_comb begin
    fold2 = 256'(fold_q[254:0]) + 256'(fold_q[260:255]) * 256'd19;
    r_d   = fold2[255] ? (fold2[254:0] + 255'd19) : fold2[254:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      fold_q <= '0;
      r_q    <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      v1_q   <= start;
      v2_q   <= v1_q;
      done_q <= v2_q;
      if (start) begin
        prod_q <= 510'(a) * 510'(b);
      end
      // First fold: 2^255 == 19 (mod p).
      if (v1_q) begin
        fold_q <= 261'(prod_q[254:0]) + 261'(prod_q[509:255]) * 261'd19;
      end
      if (v2_q) begin
        r_q <= r_d;
      end
    end
  end

  assign r    = r_q;
  assign done = done_q;

endmodule

// File: rtl/point_encode_25519.sv
// Ed25519 projective-to-compressed point encoder.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of point_encode_25519_if (start, in_x/y/z, enc, done, err, busy)
// Z^-1 is computed as Z^(p-2) by left-to-right square-and-multiply on one shared
// fe_mul_25519; then x = X/Z, y = Y/Z are formed, y is canonicalised and the sign
// of x is placed in bit 255. Every product costs a prep cycle, the multiplier
// latency and one step cycle.
module point_encode_25519
  import ed25519_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  point_encode_25519_if.slave bus
);

  state_t       state_q, state_d;
  mul_op_e      op_q, op_d;
  logic [7:0]   idx_q, idx_d;
  logic [254:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [254:0] acc_q, acc_d, xa_q, xa_d, ya_q, ya_d;
  logic         xs_q, xs_d;
  logic [255:0] enc_q, enc_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         mul_start, mul_done;
  logic [254:0] mul_a, mul_b, mul_r;

  fe_mul_25519 u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .r     (mul_r),
    .done  (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    acc_d     = acc_q;
    xa_d      = xa_q;
    ya_d      = ya_q;
    xs_d      = xs_q;
    enc_d     = enc_q;
    err_d     = err_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    mul_a     = acc_q;
    mul_b     = acc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          z_d     = bus.in_z;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if ((z_q == '0) || (z_q == P_25519)) begin
          err_d   = 1'b1;
          enc_d   = '0;
          state_d = StFinish;
        end else begin
          acc_d   = z_q;
          idx_d   = INV_TOP_IDX;
          state_d = StInvSqr;
        end
      end
      StInvSqr: begin
        mul_start = 1'b1;
        op_d      = OpSqr;
        state_d   = StMulWait;
      end
      StInvMul: begin
        mul_start = 1'b1;
        mul_b     = z_q;
        op_d      = OpMul;
        state_d   = StMulWait;
      end
      StAffX: begin
        mul_start = 1'b1;
        mul_a     = x_q;
        op_d      = OpAffX;
        state_d   = StMulWait;
      end
      StAffY: begin
        mul_start = 1'b1;
        mul_a     = y_q;
        op_d      = OpAffY;
        state_d   = StMulWait;
      end
      StMulWait: begin
        if (mul_done) begin
          unique case (op_q)
            OpSqr, OpMul: acc_d = mul_r;
            OpAffX:       xa_d  = mul_r;
            OpAffY:       ya_d  = mul_r;
            default:      acc_d = mul_r;
          endcase
          state_d = StStep;
        end
      end
      StStep: begin
        unique case (op_q)
          OpSqr, OpMul: begin
            // After a squaring, a set exponent bit still owes a multiply by Z.
            if ((op_q == OpSqr) && INV_EXP[idx_q]) begin
              state_d = StInvMul;
            end else if (idx_q == 8'd0) begin
              state_d = StAffX;
            end else begin
              idx_d   = idx_q - 8'd1;
              state_d = StInvSqr;
            end
          end
          OpAffX:  state_d = StAffY;
          OpAffY:  state_d = StCanon;
          default: state_d = StIdle;
        endcase
      end
      StCanon: begin
        ya_d = canon_fe(ya_q);
        // Subtracting the odd prime flips parity, so the sign needs no full reduction.
        xs_d = (xa_q >= P_25519) ? ~xa_q[0] : xa_q[0];
        state_d = StFinish;
      end
      StFinish: begin
        enc_d   = err_q ? '0 : {xs_q, ya_q};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpSqr;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      xs_q    <= 1'b0;
      enc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      xs_q    <= xs_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.enc  = enc_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != StIdle);

endmodule

// File: tb/tb_point_encode_25519.sv
module tb_point_encode_25519;

  localparam logic [509:0] PMOD = (510'd1 << 255) - 510'd19;
  localparam int VALID_LAT = 508 * (int'(ed25519_pkg::MUL_LAT) + 2) + 4;
  localparam int ERR_LAT   = 3;
  localparam int MAX_WAIT  = 3000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  point_encode_25519_if bus ();

  point_encode_25519 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [255:0] enc;
    logic         err;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [254:0] rand255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[254:0];
  endfunction

  // Reference model: plain modular arithmetic with the % operator.
  function automatic logic [254:0] modp(input logic [254:0] v);
    logic [509:0] t;
    t = 510'(v) % PMOD;
    return t[254:0];
  endfunction

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] t;
    t = (510'(a) * 510'(b)) % PMOD;
    return t[254:0];
  endfunction

  function automatic logic [254:0] invmod(input logic [254:0] a);
    logic [254:0] e;
    logic [254:0] r;
    logic [509:0] pm2;
    pm2 = PMOD - 510'd2;
    e   = pm2[254:0];
    r   = 255'd1;
    for (int i = 254; i >= 0; i--) begin
      r = mulmod(r, r);
      if (e[i]) r = mulmod(r, a);
    end
    return r;
  endfunction

  task automatic ref_encode(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                            output logic [255:0] enc, output logic err);
    logic [254:0] zr, zi, xa, ya;
    zr = modp(z);
    if (zr == '0) begin
      err = 1'b1;
      enc = '0;
    end else begin
      zi  = invmod(zr);
      xa  = mulmod(x, zi);
      ya  = mulmod(y, zi);
      err = 1'b0;
      enc = {xa[0], ya};
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (lat = -1 on timeout).
  task automatic run_op(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                        output logic [255:0] enc, output logic err, output int lat);
    int cnt;
    bus.start = 1'b1;
    bus.in_x  = x;
    bus.in_y  = y;
    bus.in_z  = z;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_x  = rand255();
    bus.in_y  = rand255();
    bus.in_z  = rand255();
    cnt = 1;
    lat = -1;
    while (cnt <= MAX_WAIT) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cnt;
        break;
      end
      @(posedge clk);
      cnt++;
    end
    enc = bus.enc;
    err = bus.err;
  endtask

  vec_t         vecs[6];
  logic [254:0] bx, by, pp, rx, ry, rz;
  logic [255:0] base_enc, got_enc, exp_enc;
  logic         got_err, exp_err;
  int           lat, ndone;
  logic         saw_busy;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.in_x   = '0;
    bus.in_y   = '0;
    bus.in_z   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enc", bus.enc, 256'd0);
    chk("reset_done", 256'(bus.done), 256'd0);
    chk("reset_err", 256'(bus.err), 256'd0);
    chk("reset_busy", 256'(bus.busy), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    bx = 255'h216936D3_CD6E53FE_C0A4E231_FDD6DC5C_692CC760_9525A7B2_C9562D60_8F25D51A;
    by = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
    base_enc = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
    pp = PMOD[254:0];

    vecs[0] = '{"base",     bx, by, 255'd1, base_enc, 1'b0};
    vecs[1] = '{"scaled",   mulmod(255'd2, bx), mulmod(255'd2, by), 255'd2, base_enc, 1'b0};
    vecs[2] = '{"identity", 255'd0, 255'd1, 255'd1, 256'd1, 1'b0};
    vecs[3] = '{"noncanon", pp + 255'd1, pp + 255'd1, 255'd1, (256'd1 << 255) | 256'd1, 1'b0};
    vecs[4] = '{"z_zero",   bx, by, 255'd0, 256'd0, 1'b1};
    vecs[5] = '{"z_p",      bx, by, pp, 256'd0, 1'b1};

    // Each op starts at the negedge where the previous done was seen: back-to-back.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].z, got_enc, got_err, lat);
      chk({vecs[i].name, "_enc"}, got_enc, vecs[i].enc);
      chk({vecs[i].name, "_err"}, 256'(got_err), 256'(vecs[i].err));
      chk({vecs[i].name, "_lat"}, 256'(lat), 256'(vecs[i].err ? ERR_LAT : VALID_LAT));
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", 256'(bus.done), 256'd0);
        chk("enc_held", bus.enc, base_enc);
      end
    end

    for (int i = 0; i < 4; i++) begin
      rx = rand255();
      ry = rand255();
      rz = rand255();
      ref_encode(rx, ry, rz, exp_enc, exp_err);
      run_op(rx, ry, rz, got_enc, got_err, lat);
      chk("rand_enc", got_enc, exp_enc);
      chk("rand_err", 256'(got_err), 256'(exp_err));
      chk("rand_lat", 256'(lat), 256'(VALID_LAT));
    end

    // Extra start pulses while busy must be ignored.
    rx = rand255();
    ry = rand255();
    rz = rand255();
    ref_encode(rx, ry, rz, exp_enc, exp_err);
    bus.start = 1'b1;
    bus.in_x  = rx;
    bus.in_y  = ry;
    bus.in_z  = rz;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone     = 0;
    saw_busy  = 1'b0;
    got_enc   = '0;
    for (int c = 0; c < 2700; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.done) begin
        ndone++;
        got_enc = bus.enc;
      end else if ((ndone == 0) && bus.busy && ((c % 300) == 5)) begin
        bus.start = 1'b1;
        bus.in_x  = rand255();
        bus.in_y  = rand255();
        bus.in_z  = 255'd1;
      end
    end
    bus.start = 1'b0;
    chk("busy_seen", 256'(saw_busy), 256'd1);
    chk("busy_ndone", 256'(ndone), 256'd1);
    chk("busy_enc", got_enc, exp_enc);

    // Reset in the middle of the inversion.
    bus.start = 1'b1;
    bus.in_x  = bx;
    bus.in_y  = by;
    bus.in_z  = 255'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (600) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 256'(bus.busy), 256'd0);
    chk("midrst_enc", bus.enc, 256'd0);
    chk("midrst_done", 256'(bus.done), 256'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 256'(ndone), 256'd0);

    rx = rand255();
    ry = rand255();
    rz = rand255();
    ref_encode(rx, ry, rz, exp_enc, exp_err);
    run_op(rx, ry, rz, got_enc, got_err, lat);
    chk("after_rst_enc", got_enc, exp_enc);
    chk("after_rst_err", 256'(got_err), 256'(exp_err));
    chk("after_rst_lat", 256'(lat), 256'(VALID_LAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
